// File: rtl/userio_db15_scan.sv
// userio_db15_scan
//
// Scanner for the DB15 UserIO joystick adapter (two cascaded PISO shift
// registers, 32 bits in total). Each frame pulses the adapter load line,
// clocks out 32 active-low bits and publishes two active-high 16-bit
// joystick words in a single cycle at frame end.
//
// Ports:
//   clk         system clock (40-50 MHz joystick domain)
//   reset_n     synchronous active-low reset
//   joy_data    serial data from the adapter, active-low, asynchronous
//   joy_clk     adapter shift clock (registers advance on its rising edge)
//   joy_load    adapter parallel load, active-low
//   joystick1   player-1 buttons, active-high
//   joystick2   player-2 buttons, active-high
//   frame_done  one-cycle pulse when a frame is published
//
// Parameters:
//   HALF_PERIOD  system cycles per half shift-clock period (4..255)
//   GAP_TICKS    idle half-periods between frames (1..255)
//
// Optional build macro USERIO_DB15_DEBOUNCE_EN: the outputs only update
// when two consecutive frames return identical raw bits.

module userio_db15_scan #(
  parameter int HALF_PERIOD = 25,
  parameter int GAP_TICKS   = 35
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done
);

  typedef enum logic [1:0] {GAP, LOAD, LO, HI} state_t;

  localparam logic [7:0] TICK_LAST = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_TICKS - 1);

  state_t      state;
  logic [1:0]  data_sync;  // [0] first stage, [1] stage used by the capture
  logic [7:0]  tcnt;
  logic [7:0]  gap_cnt;
  logic [4:0]  bitcnt;
  logic [31:0] raw;
  logic        tick;

`ifdef USERIO_DB15_DEBOUNCE_EN
  logic [31:0] prev;
`endif

  assign tick = (tcnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= GAP;
      data_sync  <= 2'b11;
      tcnt       <= '0;
      gap_cnt    <= '0;
      bitcnt     <= '0;
      raw        <= '1;
      joy_clk    <= 1'b0;
      joy_load   <= 1'b1;
      joystick1  <= '0;
      joystick2  <= '0;
      frame_done <= 1'b0;
`ifdef USERIO_DB15_DEBOUNCE_EN
      prev       <= '1;
`endif
    end else begin
      data_sync  <= {data_sync[0], joy_data};
      frame_done <= 1'b0;
      tcnt       <= tick ? 8'd0 : tcnt + 8'd1;

      // Line outputs are registered alongside the state so they only move
      // on tick boundaries.
      if (tick) begin
        case (state)
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt  <= '0;
              bitcnt   <= '0;
              state    <= LOAD;
              joy_load <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
          LOAD: begin
            state    <= LO;
            joy_load <= 1'b1;
          end
          LO: begin
            // Data has been stable for a full half-period since the
            // previous rising shift edge, well past the synchroniser delay.
            raw[bitcnt] <= data_sync[1];
            state       <= HI;
            joy_clk     <= 1'b1;
          end
          HI: begin
            joy_clk <= 1'b0;
            if (bitcnt == 5'd31) begin
              state      <= GAP;
              frame_done <= 1'b1;
`ifdef USERIO_DB15_DEBOUNCE_EN
              if (raw == prev) begin
                joystick1 <= ~raw[15:0];
                joystick2 <= ~raw[31:16];
              end
              prev <= raw;
`else
              joystick1 <= ~raw[15:0];
              joystick2 <= ~raw[31:16];
`endif
            end else begin
              bitcnt <= bitcnt + 5'd1;
              state  <= LO;
            end
          end
          default: state <= GAP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_userio_db15_scan.sv
// Bench for userio_db15_scan: two instances (default timing and the minimum
// divider with a short gap), each driven by a shift-register adapter model.
// Expected line activity and outputs are derived from elapsed cycle counts
// and the patterns handed to the adapter.

module tb_userio_db15_scan;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Patterns for the default-timing instance, one per loaded frame.
  logic [31:0] dir_q[$];

  logic [1:0]  load_w;
  logic [1:0]  done_w;
  logic [31:0] j1_w;
  logic [31:0] j2_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cfg
      localparam int HP = (gi == 0) ? 25 : 4;
      localparam int GT = (gi == 0) ? 35 : 3;
      localparam int FT = GT + 65;  // ticks per frame

      logic        joy_data, joy_clk, joy_load, frame_done;
      logic [15:0] joystick1, joystick2;
      logic [31:0] shreg = '1;
      logic [31:0] cur_pat = '1;
      logic        clk_d = 1'b0;

      userio_db15_scan #(.HALF_PERIOD(HP), .GAP_TICKS(GT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .joy_data   (joy_data),
        .joy_clk    (joy_clk),
        .joy_load   (joy_load),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .frame_done (frame_done)
      );

      assign load_w[gi]          = joy_load;
      assign done_w[gi]          = frame_done;
      assign j1_w[gi*16 +: 16]   = joystick1;
      assign j2_w[gi*16 +: 16]   = joystick2;

      // Adapter: parallel load while joy_load is low, shift on joy_clk rise.
      always @(negedge clk) begin
        clk_d <= joy_clk;
        if (!joy_load) shreg <= cur_pat;
        else if (joy_clk && !clk_d) shreg <= {1'b1, shreg[31:1]};
      end
      assign joy_data = shreg[0];

      initial begin : model
        int n, t, q, rises;
        logic exp_load, exp_clk, exp_done, clk_prev;
        logic [15:0] e1, e2;
        logic [31:0] prev;
        n = 0; rises = 0; clk_prev = 1'b0;
        e1 = '0; e2 = '0; prev = '1;
        forever begin
          @(posedge clk); #1;
          if (!reset_n) begin
            n = 0; e1 = '0; e2 = '0; prev = '1; rises = 0;
          end else begin
            n++;
          end
          t = n / HP;
          q = t % FT;
          exp_load = (q != GT);
          exp_clk  = (q > GT) && (((q - GT - 1) % 2) == 1);
          exp_done = (n % HP == 0) && (t > 0) && (q == 0);
          if (exp_done) begin
`ifdef USERIO_DB15_DEBOUNCE_EN
            if (cur_pat == prev) begin
              e1 = ~cur_pat[15:0];
              e2 = ~cur_pat[31:16];
            end
            prev = cur_pat;
`else
            e1 = ~cur_pat[15:0];
            e2 = ~cur_pat[31:16];
`endif
          end
          if (joy_clk && !clk_prev) rises++;
          clk_prev = joy_clk;
          chk($sformatf("cfg%0d joy_load n=%0d", gi, n), 32'(joy_load), 32'(exp_load));
          chk($sformatf("cfg%0d joy_clk n=%0d", gi, n), 32'(joy_clk), 32'(exp_clk));
          chk($sformatf("cfg%0d frame_done n=%0d", gi, n), 32'(frame_done), 32'(exp_done));
          chk($sformatf("cfg%0d joystick1 n=%0d", gi, n), 32'(joystick1), 32'(e1));
          chk($sformatf("cfg%0d joystick2 n=%0d", gi, n), 32'(joystick2), 32'(e2));
          if (exp_done) begin
            chk($sformatf("cfg%0d clk_rises", gi), rises, 32);
            rises = 0;
          end
          if (exp_done || n == 1) begin
            if (gi == 0 && dir_q.size() > 0) cur_pat = dir_q.pop_front();
            else cur_pat = $urandom();
          end
        end
      end
    end
  endgenerate

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!done_w[0] && k < 6000);
    if (!done_w[0]) begin
      checks++;
      failures++;
      $display("FAIL wait_done timeout actual=no_pulse required=pulse");
    end
    $display("frame cyc=%0d joystick1=%h joystick2=%h", cyc, j1_w[15:0], j2_w[15:0]);
  endtask

  task automatic chk_words(input string name, input logic [15:0] e1, input logic [15:0] e2);
    chk({name, " joystick1"}, 32'(j1_w[15:0]), 32'(e1));
    chk({name, " joystick2"}, 32'(j2_w[15:0]), 32'(e2));
  endtask

  logic deb;
  int   t_first, pulses;

  initial begin
`ifdef USERIO_DB15_DEBOUNCE_EN
    deb = 1'b1;
`else
    deb = 1'b0;
`endif
    dir_q = {32'hFFFF_FFFF, 32'hFFFE_7FFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
             32'hFFFF_FFFE,                      // aborted by reset
             32'hFFFF_FFFE, 32'hFFFF_FFFE,
             32'hFFFF_FFEF, 32'hFFFF_FFFF, 32'hFFFF_FFEF, 32'hFFFF_FFFF,
             32'hFFFF_FFEF, 32'hFFFF_FFEF};

    repeat (10) @(negedge clk);
    chk_words("reset", 16'h0000, 16'h0000);
    chk("reset joy_load", 32'(load_w[0]), 32'd1);
    chk("reset frame_done", 32'(done_w[0]), 32'd0);
    reset_n = 1'b1;

    for (int i = 1; i <= 875; i++) begin
      @(posedge clk); #1;
      if (i == 874) chk("joy_load before 875", 32'(load_w[0]), 32'd1);
      if (i == 875) chk("joy_load at 875", 32'(load_w[0]), 32'd0);
    end

    wait_done();
    t_first = cyc;
    chk_words("idle", 16'h0000, 16'h0000);

    wait_done();
    chk("frame spacing", cyc - t_first, 2500);
    chk_words("bit map", 16'h8000, 16'h0001);

    wait_done();
    if (deb) chk_words("hold up f1", 16'h8000, 16'h0001);
    else     chk_words("hold up f1", 16'h0001, 16'h0000);
    wait_done();
    chk_words("hold up f2", 16'h0001, 16'h0000);

    // Land inside bit 20 of the next frame, then reset.
    repeat (1910) @(negedge clk);
    chk("pre-reset joystick1", 32'(j1_w[15:0]), 32'h0001);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk_words("mid reset", 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (done_w[0]) pulses++;
    end
    chk("aborted frame pulses", pulses, 0);

    wait_done();
    if (deb) chk_words("resume f1", 16'h0000, 16'h0000);
    else     chk_words("resume f1", 16'h0001, 16'h0000);
    wait_done();
    chk_words("resume f2", 16'h0001, 16'h0000);

    // Button A toggled in alternate frames, then held for two frames.
    for (int f = 0; f < 4; f++) begin
      wait_done();
      chk($sformatf("toggle A f%0d", f), 32'(j1_w[4]), deb ? 32'd0 : 32'((f % 2) == 0));
    end
    wait_done();
    chk("hold A f1", 32'(j1_w[4]), deb ? 32'd0 : 32'd1);
    wait_done();
    chk("hold A f2", 32'(j1_w[4]), 32'd1);

    repeat (3000) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/userio_db15_scan.md
# userio_db15_scan

Serial scanner for the DB15 UserIO joystick adapter, which is built from two cascaded parallel-in/serial-out shift registers. It sits upstream of the emu-level joystick multiplexer and supplies the `joydb_*` words.
- Each frame it drives the adapter's load and clock lines and shifts in 32 active-low bits.
- It publishes two 16-bit active-high joystick words atomically at frame end.
- It runs on the 40–50 MHz joystick clock domain.

## Interface
Parameters:
- `HALF_PERIOD`, default 25: system cycles per half shift-clock period ("tick"). Legal range is 4..255.
- `GAP_TICKS`, default 35: idle ticks between frames. Legal range is 1..255.

Ports:
- `clk`  in  1  system clock; the block uses one clock only.
- `reset_n`  in  1  synchronous, active-low reset.
- `joy_data`  in  1  serial data from the adapter; active-low (0 = pressed); asynchronous.
- `joy_clk`  out  1  adapter shift clock; the registers advance on its rising edge.
- `joy_load`  out  1  adapter parallel load; active-low.
- `joystick1`  out  16  player-1 buttons, active-high: bits `[3:0]` = U D L R, `[9:4]` = A B C X Y Z, `[10]` = Start, `[11]` = Mode, `[15:12]` are spare.
- `joystick2`  out  16  player-2 buttons, same layout as `joystick1`.
- `frame_done`  out  1  one-cycle pulse when a frame completes.

## Operation
- **Input synchroniser:** `joy_data` passes through a 2-FF synchroniser before any use.
- **Tick generator:** `tcnt` counts 0..HALF_PERIOD-1 and wraps. `tick` is asserted when `tcnt == HALF_PERIOD-1`. Every state transition happens on `tick`.
- **States:** GAP, LOAD, LO, HI.
  - GAP: `joy_load`=1, `joy_clk`=0. Stays for GAP_TICKS ticks, then goes to LOAD with `bitcnt`=0.
  - LOAD: `joy_load`=0, `joy_clk`=0. Lasts one tick, then goes to LO.
  - LO: `joy_load`=1, `joy_clk`=0. On the closing tick, the synchronised data is captured as `raw[bitcnt]`, then the state goes to HI.
  - HI: `joy_clk`=1. On the closing tick:
    - if `bitcnt` == 31, go to GAP and publish;
    - otherwise increment `bitcnt` and go to LO.
- **Bit mapping:** stream bit k (k = 0..31) maps to `raw[k]`.
  - `joystick1` = ~`raw[15:0]`.
  - `joystick2` = ~`raw[31:16]`.
- **Publish:** both output words update in the same cycle and `frame_done` pulses in that same cycle. A partial frame is never visible on the outputs.
- **Counter widths:**
  - `bitcnt` is 5 bits and never wraps mid-frame.
  - The gap counter is 8 bits.
- **Reset behaviour:** `reset_n` low in any state, including mid-frame, returns the block to GAP with every counter at 0. The partial frame is discarded.

## Timing
- **Reset values:**
  - `joystick1` = `joystick2` = 16'h0000
  - `joy_clk` = 0
  - `joy_load` = 1
  - `frame_done` = 0
  - state = GAP
- **First LOAD:** `joy_load` falls GAP_TICKS×HALF_PERIOD cycles after `reset_n` rises.
- **Frame length:** (1 + 64 + GAP_TICKS)×HALF_PERIOD cycles. With the defaults this is 2500 cycles, which is 50 µs at 50 MHz.
- **Capture latency:** bit k is captured (1 + 2k + 1)×HALF_PERIOD − 1 cycles after `joy_load` falls. It reflects `joy_data` from 2 cycles earlier, because of the synchroniser.
- **Publish latency:** outputs change on the cycle after the closing tick of the 32nd HI, together with `frame_done`.
- **Line transitions:** `joy_clk` and `joy_load` change only on tick boundaries. They are registered outputs and glitch-free.

## Configuration
- Macro: `USERIO_DB15_DEBOUNCE_EN`.
- **Defined:**
  - A 32-bit `prev` register holds the previous frame's raw bits.
  - At publish, the outputs update only if `raw` == `prev`. `prev` is loaded with `raw` every frame.
  - `frame_done` still pulses every frame.
  - A stable press therefore appears after 2 frames.
  - `prev` resets to all 1s.
- **Undefined:**
  - Outputs update on every frame.
  - No `prev` register is instantiated.

## Test plan
- **Reset values:** hold `reset_n`=0 for 10 cycles, then release.
  - All outputs read 0, `joy_load`=1, `joy_clk`=0.
  - `joy_load` falls at cycle 875 with the defaults.
- **Idle adapter:** the adapter model returns all 1s (nothing pressed).
  - After the first `frame_done`, `joystick1`=`joystick2`=16'h0000.
  - Exactly 32 `joy_clk` rising edges occur per frame.
  - The spacing between `frame_done` pulses is 2500 cycles.
- **Bit mapping:** the adapter model presents 32'hFFFE_7FFF, i.e. bit 15 (player-1) and bit 16 (player-2 Up) are low.
  - `joystick1`=16'h8000 and `joystick2`=16'h0001.
  - Both words change in the same cycle as `frame_done`.
- **Mid-frame reset:** assert `reset_n`=0 during bit 20 of a frame with player-1 Up held.
  - Outputs clear to 0 on the next cycle.
  - No `frame_done` pulse is produced for the aborted frame.
  - Normal scanning resumes after GAP.
- **Debounce, with `USERIO_DB15_DEBOUNCE_EN`:** toggle player-1 button A in alternate frames.
  - `joystick1[4]` stays 0.
  - Holding A for 2 frames sets `joystick1[4]`=1 at the second `frame_done`.
  - Without the macro, `joystick1[4]` follows every frame.
- **Minimum divider:** set `HALF_PERIOD`=4 and feed random data that is stable per bit.
  - Every captured bit matches the model, confirming the synchroniser margin.
